inst_fetch_stage: RTL and testbench
===================================

// Module: inst_fetch_stage
// PURPOSE
//  IF stage of the MIPS 5-stage pipeline, directly upstream of the ID-stage controller.
//  Owns the PC and issues req/ack fetches to instruction memory.
//  Holds the IF/ID register (if_inst feeds the controller's inst input).
//  Absorbs ID stalls with a one-entry skid buffer; flushes on branch/jump redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  NOP_INST  32'h2000_0000  bubble encoding (addi $0,$0,0), driven on if_inst when !if_valid
// PORTS
//  clk             in   1   main clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  en              in   1   cpu enable (controller cpu_en); low = freeze, treated as stall
//  stall           in   1   hazard hold: ID not accepting; IF/ID must hold
//  redirect_valid  in   1   one-cycle pulse: taken branch / jump / jr resolved
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req        out  1   fetch request, held until imem_ack
//  imem_addr       out  32  fetch address, word aligned, stable while imem_req
//  imem_ack        in   1   one-cycle completion pulse; earliest 1 cycle after req rises
//  imem_rdata      in   32  instruction, valid only in the imem_ack cycle
//  if_valid        out  1   IF/ID holds a real instruction
//  if_pc           out  32  PC of if_inst
//  if_pc4          out  32  if_pc + 4, used as the branch base
//  if_inst         out  32  instruction to the controller; NOP_INST when !if_valid
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC.
//   Also: if_valid=0, if_inst=NOP_INST, if_pc=0, if_pc4=4, skid buffer empty.
//   imem_req rises on the first clk edge after rst_n deasserts.
//  hold = stall | ~en.
//  FSM states:
//   FETCH  imem_req=1, imem_addr=pc.
//    ack & ~hold & ~redirect: IF/ID <= {1,pc,pc+4,rdata}; pc<=pc+4; stay.
//    ack & hold: skid <= {pc,rdata}; pc<=pc+4; go to FULL.
//   FULL   imem_req=0.
//    ~hold: IF/ID <= skid; go to FETCH.
//   DRAIN  imem_req=1, addr = the killed request's address, held.
//    On ack: drop rdata; go to FETCH; pc holds the pending target.
//  Redirect priority: redirect > hold > ack. It applies even while en=0.
//   On redirect: if_valid<=0, skid cleared, pc<=redirect_pc.
//   FETCH without ack -> DRAIN; the outstanding request must complete.
//   FETCH with ack in the same cycle -> rdata dropped; stay FETCH at target.
//   FULL -> FETCH at target.
//   DRAIN -> stay DRAIN; pending target overwritten by the newest redirect.
//  While hold and no ack: IF/ID, pc and state are unchanged.
//   An outstanding request is never withdrawn: imem_req stays high.
//  IF/ID with ~hold and no new data: if_valid<=0, if_inst<=NOP_INST (bubble).
//  Latency: ack at cycle t -> if_valid/if_inst visible at t+1.
//   Throughput is 1 inst/clk with a zero-wait memory.
//  Arithmetic: all PC adds are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 = 0).
//  imem_addr changes only in a cycle after an ack, or when leaving FULL.
// STRUCTURE
//  mips_define.vh: IF_STATE_FETCH/FULL/DRAIN encodings (2-bit) and the NOP_INST default.
//  Sub-module fetch_skid_buf (1 entry {pc,inst}, load/unload/clear, full flag).
//  The FSM, PC and IF/ID register stay in inst_fetch_stage.
// TESTING
//  1 Zero-wait memory (ack 1 cycle after each req), no stall.
//    -> addrs 0,4,8,C on consecutive transactions; if_pc tracks the addrs 1 cycle after ack.
//  2 stall=1 at the ack of addr 8.
//    -> FULL, imem_req=0; if_inst holds the addr-4 inst.
//    -> Release stall: if_pc=8 next cycle, then fetch resumes at 0xC.
//  3 redirect_pc=0x40 while the req for 0x10 waits 3 cycles.
//    -> DRAIN; req stays at 0x10 until ack; data dropped; next req at 0x40; if_valid=0 meanwhile.
//  4 redirect (0x80) in the same cycle as an ack, while stall=1.
//    -> rdata dropped; skid empty; if_valid=0; next req at 0x80.
//  5 en=0 for 4 cycles with no ack.
//    -> all outputs frozen; a redirect during en=0 still flushes and retargets the PC.
//  6 rst_n pulsed low mid-DRAIN.
//    -> immediate reset values; first req after release at RESET_PC.
//    -> Also: a PC at 0xFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/inst_fetch_stage_pkg.sv
// Shared definitions for the IF stage.
//   if_state_e       : fetch FSM state encodings (2-bit)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INST_DEFAULT : bubble encoding (addi $0,$0,0)
//   word_align()     : clears bits [1:0] of an address
package inst_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_STATE_FETCH = 2'd0,
        IF_STATE_FULL  = 2'd1,
        IF_STATE_DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h2000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_stage_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, inst} pair while ID stalls.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears full only)
//   load                  capture load_pc/load_inst, mark full
//   unload                entry consumed, mark empty
//   clear                 flush on redirect (wins over load)
//   load_pc, load_inst    entry to capture
//   full                  entry valid
//   out_pc, out_inst      stored entry
module inst_fetch_stage_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        full,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic        full_q, full_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_comb begin
        full_d = full_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            pc_d   = load_pc;
            inst_d = load_inst;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload is only meaningful while full_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign full     = full_q;
    assign out_pc   = pc_q;
    assign out_inst = inst_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// IF stage of the MIPS 5-stage pipeline: owns the PC, issues req/ack fetches,
// holds the IF/ID register, absorbs ID stalls with a one-entry skid buffer and
// flushes on branch/jump redirects.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   en                          cpu enable; low freezes the stage like a stall
//   stall                       ID not accepting; IF/ID holds
//   redirect_valid/redirect_pc  one-cycle redirect pulse and target
//   imem_req/imem_addr          fetch request (held until ack) and address
//   imem_ack/imem_rdata         completion pulse and instruction
//   if_valid/if_pc/if_pc4/if_inst  IF/ID register contents
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic [31:0] inst_q, inst_d;

    logic        hold;
    logic        ack;
    logic [31:0] redir_target;
    logic        skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0] skid_pc, skid_inst;

    assign hold         = stall | ~en;
    // An ack only means something while a request is actually outstanding.
    assign ack          = imem_ack & req_q;
    assign redir_target = word_align(redirect_pc);

    inst_fetch_stage_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_pc   (pc_q),
        .load_inst (imem_rdata),
        .full      (skid_full),
        .out_pc    (skid_pc),
        .out_inst  (skid_inst)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        ifpc_d      = ifpc_q;
        ifpc4_d     = ifpc4_q;
        inst_d      = inst_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        // ID consumes IF/ID whenever it is not held: bubble unless refilled below.
        if (!hold) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        if (redirect_valid) begin
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            skid_clear = 1'b1;
            pc_d       = redir_target;
            case (state_q)
                // A request still in flight must complete before the target is fetched.
                IF_STATE_FETCH: state_d = (req_q && !ack) ? IF_STATE_DRAIN : IF_STATE_FETCH;
                IF_STATE_DRAIN: state_d = ack ? IF_STATE_FETCH : IF_STATE_DRAIN;
                default:        state_d = IF_STATE_FETCH;
            endcase
        end else begin
            case (state_q)
                IF_STATE_FETCH: begin
                    if (ack) begin
                        pc_d = pc_q + 32'd4;
                        if (hold) begin
                            skid_load = 1'b1;
                            state_d   = IF_STATE_FULL;
                        end else begin
                            valid_d = 1'b1;
                            ifpc_d  = pc_q;
                            ifpc4_d = pc_q + 32'd4;
                            inst_d  = imem_rdata;
                        end
                    end
                end
                IF_STATE_FULL: begin
                    if (!hold) begin
                        state_d = IF_STATE_FETCH;
                        if (skid_full) begin
                            skid_unload = 1'b1;
                            valid_d     = 1'b1;
                            ifpc_d      = skid_pc;
                            ifpc4_d     = skid_pc + 32'd4;
                            inst_d      = skid_inst;
                        end
                    end
                end
                IF_STATE_DRAIN: begin
                    if (ack) begin
                        state_d = IF_STATE_FETCH;
                    end
                end
                default: state_d = IF_STATE_FETCH;
            endcase
        end

        // In DRAIN the killed request's address stays on the bus; otherwise
        // the bus follows the PC, so it only moves after an ack or a redirect.
        addr_d = (state_d == IF_STATE_DRAIN) ? addr_q : pc_d;
        req_d  = (state_d != IF_STATE_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_STATE_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            ifpc_q  <= 32'd0;
            ifpc4_q <= 32'd4;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            inst_q  <= inst_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = ifpc_q;
    assign if_pc4    = ifpc4_q;
    assign if_inst   = inst_q;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: random-latency instruction memory, a program-order
// reference model feeding a scoreboard queue, and a negedge monitor that pops
// and compares every instruction ID consumes.
module tb_inst_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc, if_pc4, if_inst;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are inspected 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input logic [31:0] a, input int budget, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (imem_req && imem_addr == a) hit = 1'b1;
            else step();
        end
        chk(name, {31'd0, hit}, 32'd1);
    endtask

    // ---------------- reference model (program order) ----------------
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc = RST_PC;
    bit          killed = 1'b0;
    bit          ev_valid = 1'b0, ev_redirect, ev_hold, ev_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q.delete();
            exp_pc   = RST_PC;
            killed   = 1'b0;
            ev_valid = 1'b0;
        end else begin
            ev_valid    = 1'b1;
            ev_redirect = redirect_valid;
            ev_hold     = stall | !en;
            ev_ack      = imem_ack;
            if (redirect_valid) begin
                // Everything fetched but not yet consumed is wrong-path.
                sb_q.delete();
                killed = imem_req && !imem_ack;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (imem_ack) begin
                if (killed) killed = 1'b0;
                else begin
                    sb_q.push_back({exp_pc, imem_rdata});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- instruction memory ----------------
    int          lat_force = -1;
    bit          mem_block = 1'b0;
    bit          outstanding = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr = 32'd0;

    initial forever begin
        bit b2b;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            imem_ack    = 1'b0;
            outstanding = 1'b0;
        end else begin
            b2b = imem_ack;
            if (imem_ack) begin
                imem_ack    = 1'b0;
                outstanding = 1'b0;
            end
            if (outstanding) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, req_addr);
            end
            if (imem_req && !outstanding) begin
                outstanding = 1'b1;
                req_addr    = imem_addr;
                chk("fetch_addr", imem_addr, exp_pc);
                wait_cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(3, 0));
                if (!b2b && wait_cnt == 0) wait_cnt = 1;
            end
            if (outstanding && !mem_block) begin
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = $urandom;
                end else wait_cnt--;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_valid, prev_req;
    logic [31:0] prev_pc, prev_inst, prev_addr;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n && ev_valid) begin
            if (ev_redirect) begin
                chk("redirect_flush", {31'd0, if_valid}, 32'd0);
            end else if (ev_hold) begin
                chk("hold_valid", {31'd0, if_valid}, {31'd0, prev_valid});
                chk("hold_pc", if_pc, prev_pc);
                chk("hold_inst", if_inst, prev_inst);
                if (!ev_ack) begin
                    chk("hold_req", {31'd0, imem_req}, {31'd0, prev_req});
                    chk("hold_addr", imem_addr, prev_addr);
                end
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("deliver_valid", {31'd0, if_valid}, 32'd1);
                chk("deliver_pc", if_pc, e[63:32]);
                chk("deliver_pc4", if_pc4, e[63:32] + 32'd4);
                chk("deliver_inst", if_inst, e[31:0]);
            end else begin
                chk("bubble_valid", {31'd0, if_valid}, 32'd0);
            end
            if (!if_valid) chk("invalid_nop", if_inst, NOP);
            ev_valid = 1'b0;
        end
        prev_valid = if_valid;
        prev_pc    = if_pc;
        prev_inst  = if_inst;
        prev_req   = imem_req;
        prev_addr  = imem_addr;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a_save, p_save;
        logic        v_save;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_inst", if_inst, NOP);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd4);
        step();
        step();
        rst_n = 1'b1;
        lat_force = 0;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RST_PC);

        // Zero-wait stream, then stall exactly at the ack of address 8.
        wait_req(32'h4, 10, "t1_addr4");
        wait_req(32'h8, 10, "t1_addr8");
        for (int i = 0; i < 5 && !imem_ack; i++) step();
        chk("t2_ack8_seen", {31'd0, imem_ack}, 32'd1);
        stall = 1'b1;
        step();
        chk("t2_full_req", {31'd0, imem_req}, 32'd0);
        chk("t2_hold_pc", if_pc, 32'h4);
        step();
        step();
        chk("t2_full_req2", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        lat_force = 3;
        step();
        chk("t2_unload_pc", if_pc, 32'h8);
        chk("t2_unload_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
        chk("t2_resume_addr", imem_addr, 32'hC);

        // Redirect while 0x10 is still waiting.
        wait_req(32'h10, 12, "t3_req10");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk("t3_drain_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 10 && !imem_ack; i++) begin
            chk("t3_drain_addr", imem_addr, 32'h10);
            step();
        end
        lat_force = 2;
        step();
        chk("t3_target_addr", imem_addr, 32'h40);
        chk("t3_target_req", {31'd0, imem_req}, 32'd1);
        chk("t3_after_valid", {31'd0, if_valid}, 32'd0);

        // Redirect coinciding with an ack while stalled.
        for (int i = 0; i < 10 && !imem_ack; i++) step();
        chk("t4_ack_seen", {31'd0, imem_ack}, 32'd1);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h80);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        stall = 1'b0;
        step();
        chk("t4_skid_empty", {31'd0, if_valid}, 32'd0);

        // Freeze with en=0 and no ack, then redirect while frozen.
        mem_block = 1'b1;
        step();
        en = 1'b0;
        step();
        a_save = imem_addr;
        p_save = if_pc;
        v_save = if_valid;
        for (int i = 0; i < 3; i++) step();
        chk("t5_frz_addr", imem_addr, a_save);
        chk("t5_frz_pc", if_pc, p_save);
        chk("t5_frz_valid", {31'd0, if_valid}, {31'd0, v_save});
        chk("t5_frz_req", {31'd0, imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("t5_redir_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_drain_addr", imem_addr, a_save);
        mem_block = 1'b0;
        lat_force = -1;
        step();
        en = 1'b1;
        wait_req(32'h100, 20, "t5_target");

        // Reset in the middle of a drain.
        mem_block      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_addr", imem_addr, RST_PC);
        chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_rst_inst", if_inst, NOP);
        chk("t6_rst_pc4", if_pc4, 32'd4);
        mem_block = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_first_req", {31'd0, imem_req}, 32'd1);
        chk("t6_first_addr", imem_addr, RST_PC);

        // PC wrap at the top of the address space.
        for (int i = 0; i < 4; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        wait_req(32'hFFFF_FFFC, 20, "wrap_top");
        wait_req(32'h0, 20, "wrap_zero");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            stall          = ($urandom_range(3, 0) == 0);
            en             = ($urandom_range(9, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = ($urandom_range(2, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                         : $urandom;
            step();
        end
        stall          = 1'b0;
        en             = 1'b1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
